// File: rtl/seq_mult_nbit_pkg.sv
// -----------------------------------------------------------------------------
// seq_mult_nbit_pkg
// Shared definitions for the iterative shift-add multiplier.
//   DEF_WIDTH : default operand width of seq_mult_nbit
//   state_e   : 2-bit FSM encoding (IDLE=0, CALC=1, DONE=2)
// No ports; imported by seq_mult_nbit and its testbench.
// -----------------------------------------------------------------------------
package seq_mult_nbit_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_mult_nbit_addsub.sv
// -----------------------------------------------------------------------------
// addsub_nbit
// W-bit adder/subtractor used for the multiplier accumulator update.
// Subtraction is formed as a + ~b + 1 so a single adder serves both modes.
// Ports:
//   a_i   in  W  first operand (accumulator)
//   b_i   in  W  second operand (partial product)
//   sub_i in  1  1 = a - b, 0 = a + b
//   sum_o out W  result, modulo 2^W
// -----------------------------------------------------------------------------
module addsub_nbit #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] sum_o
);

  logic [W-1:0] b_x;

  // Conditional one's complement; the +1 arrives as the carry-in term.
  assign b_x   = b_i ^ {W{sub_i}};
  assign sum_o = a_i + b_x + W'(sub_i);

endmodule

// File: rtl/seq_mult_nbit.sv
// -----------------------------------------------------------------------------
// seq_mult_nbit
// Iterative shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product, one
// partial product per clock, unsigned or two's-complement per operation.
// Valid/ready handshake on both sides; not pipelined (one op in flight).
// Ports:
//   clk        in   1        system clock, rising edge
//   rst        in   1        synchronous active-high reset
//   in_valid   in   1        op1/op2/is_signed valid
//   in_ready   out  1        accepting an operation (IDLE only)
//   op1        in   WIDTH    multiplicand
//   op2        in   WIDTH    multiplier
//   is_signed  in   1        1 = both operands two's complement
//   out_valid  out  1        P holds a completed product
//   out_ready  in   1        consumer takes P
//   P          out  2*WIDTH  product
//   busy       out  1        operation in CALC or DONE
// -----------------------------------------------------------------------------
module seq_mult_nbit
  import seq_mult_nbit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     op1,
  input  logic [WIDTH-1:0]     op2,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   P,
  output logic                 busy
);

  localparam int PW = 2 * WIDTH;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic              sgn_q, sgn_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     p_q, p_d;
  logic              ovld_q, ovld_d;

  logic              last_iter;
  logic              mbit;
  logic              sub;
  logic [PW-1:0]     pp;
  logic [PW-1:0]     sum;

  // Multiplicand is widened once at acceptance so every partial product
  // is a plain left shift of the stored value.
  function automatic logic [PW-1:0] extend(input logic [WIDTH-1:0] v,
                                           input logic             s);
    extend = {{WIDTH{s & v[WIDTH-1]}}, v};
  endfunction

  // Multiplier bit selected by the iteration counter.
  always_comb begin
    mbit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt_q == CNT_W'(i)) mbit = mplier_q[i];
    end
  end

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  assign pp        = mbit ? (mcand_q << cnt_q) : '0;
  // The multiplier sign bit carries weight -2^(W-1) in two's complement,
  // so its partial product is subtracted. Subtracting zero is harmless.
  assign sub       = sgn_q & last_iter;

  addsub_nbit #(.W(PW)) u_addsub (
    .a_i   (acc_q),
    .b_i   (pp),
    .sub_i (sub),
    .sum_o (sum)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sgn_d    = sgn_q;
    acc_d    = acc_q;
    p_d      = p_q;
    ovld_d   = ovld_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d  = extend(op1, is_signed);
          mplier_d = op2;
          sgn_d    = is_signed;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          p_d     = sum;
          ovld_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          ovld_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        ovld_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      ovld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      ovld_q  <= ovld_d;
    end
  end

  // Operand and accumulator registers are reloaded on every acceptance,
  // so they need no reset.
  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    sgn_q    <= sgn_d;
    acc_q    <= acc_d;
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_CALC) || (state_q == S_DONE);
  assign out_valid = ovld_q;
  assign P         = p_q;

endmodule

// File: tb/tb_seq_mult_nbit.sv
// -----------------------------------------------------------------------------
// tb_seq_mult_nbit
// Scoreboard bench for seq_mult_nbit at WIDTH = 2, 8 and 16. Expected
// products come from a signed/unsigned integer reference and are queued
// when an operation is driven, then popped when the DUT presents P.
// -----------------------------------------------------------------------------
module tb_seq_mult_nbit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        iv2, ir2, sg2, ov2, or2, bz2;
  logic [1:0]  a2, b2;
  logic [3:0]  p2;

  logic        iv8, ir8, sg8, ov8, or8, bz8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  logic        iv16, ir16, sg16, ov16, or16, bz16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] q2[$];
  logic [63:0] q8[$];
  logic [63:0] q16[$];

  seq_mult_nbit #(.WIDTH(2)) u_w2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .op1(a2), .op2(b2),
    .is_signed(sg2), .out_valid(ov2), .out_ready(or2), .P(p2), .busy(bz2)
  );

  seq_mult_nbit #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .op1(a8), .op2(b8),
    .is_signed(sg8), .out_valid(ov8), .out_ready(or8), .P(p8), .busy(bz8)
  );

  seq_mult_nbit #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .op1(a16), .op2(b16),
    .is_signed(sg16), .out_valid(ov16), .out_ready(or16), .P(p16), .busy(bz16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Integer reference: interpret operands at width w, multiply, wrap to 2w.
  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic s);
    longint sa, sb, pr;
    logic [63:0] m;
    sa = longint'(a);
    sb = longint'(b);
    if (s && a[w-1]) sa = sa - (longint'(1) << w);
    if (s && b[w-1]) sb = sb - (longint'(1) << w);
    pr = sa * sb;
    m  = (64'd1 << (2 * w)) - 64'd1;
    return 64'(pr) & m;
  endfunction

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int t = 0;
    while (!ir8 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!ir8) check("send8_timeout", 64'd0, 64'd1);
    iv8 = 1'b1;
    a8  = a;
    b8  = b;
    sg8 = s;
    q8.push_back(ref_mul(8, {24'd0, a}, {24'd0, b}, s));
    @(negedge clk);
    iv8 = 1'b0;
    a8  = 8'($urandom);
    b8  = 8'($urandom);
    sg8 = 1'($urandom);
    check("rdy_after_acc8", {63'd0, ir8}, 64'd0);
  endtask

  task automatic recv8(input string tag);
    int t = 0;
    logic [63:0] e;
    or8 = 1'b1;
    while (!ov8 && t < 50) begin
      check("rdy_low8", {63'd0, ir8}, 64'd0);
      @(negedge clk);
      t++;
    end
    if (!ov8) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
      return;
    end
    check("rdy_low_done8", {63'd0, ir8}, 64'd0);
    e = (q8.size() > 0) ? q8.pop_front() : 64'hDEAD;
    check(tag, {48'd0, p8}, e);
    @(negedge clk);
    check({tag, "_ovclr"}, {63'd0, ov8}, 64'd0);
    check({tag, "_rdy"}, {63'd0, ir8}, 64'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] e;
    int lat;
    int sent;
    int cyc;

    rst = 1'b1;
    iv2 = 0; a2 = 0; b2 = 0; sg2 = 0; or2 = 0;
    iv8 = 0; a8 = 0; b8 = 0; sg8 = 0; or8 = 0;
    iv16 = 0; a16 = 0; b16 = 0; sg16 = 0; or16 = 0;
    @(negedge clk);
    @(negedge clk);
    check("rst_p2", {60'd0, p2}, 64'd0);
    check("rst_ov8", {63'd0, ov8}, 64'd0);
    check("rst_rdy8", {63'd0, ir8}, 64'd1);
    check("rst_busy8", {63'd0, bz8}, 64'd0);
    check("rst_p8", {48'd0, p8}, 64'd0);
    check("rst_p16", {32'd0, p16}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // WIDTH=2 exhaustive, both modes, fixed latency
    or2 = 1'b1;
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 4; a++) begin
        for (int b = 0; b < 4; b++) begin
          iv2 = 1'b1;
          a2  = 2'(a);
          b2  = 2'(b);
          sg2 = 1'(s);
          q2.push_back(ref_mul(2, 32'(a), 32'(b), 1'(s)));
          @(negedge clk);
          iv2 = 1'b0;
          a2  = 2'($urandom);
          b2  = 2'($urandom);
          lat = 0;
          while (!ov2 && lat < 10) begin
            @(negedge clk);
            lat++;
          end
          check("w2_latency", 64'(lat), 64'd2);
          e = (q2.size() > 0) ? q2.pop_front() : 64'hDEAD;
          check("w2_prod", {60'd0, p2}, e);
          @(negedge clk);
        end
      end
    end

    // WIDTH=8 directed
    send8(8'd255, 8'd255, 1'b0);
    recv8("u255x255");
    check("u255x255_const", {48'd0, p8}, 64'hFE01);
    send8(8'd0, 8'd173, 1'b0);
    recv8("u0x173");
    send8(8'hFD, 8'h05, 1'b1);
    recv8("s_m3x5");
    check("s_m3x5_const", {48'd0, p8}, 64'hFFF1);
    send8(8'h80, 8'h80, 1'b1);
    recv8("s_m128xm128");
    check("s_m128_const", {48'd0, p8}, 64'h4000);
    send8(8'h7F, 8'h80, 1'b1);
    recv8("s_127xm128");
    check("s_127_const", {48'd0, p8}, 64'hC080);
    send8(8'h00, 8'h9C, 1'b1);
    recv8("s_0xneg");

    // Backpressure: hold DONE for 5 cycles, poke in_valid meanwhile
    or8 = 1'b0;
    send8(8'd12, 8'd10, 1'b0);
    cyc = 0;
    while (!ov8 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    e = (q8.size() > 0) ? q8.pop_front() : 64'hDEAD;
    for (int k = 0; k < 5; k++) begin
      check("bp_p", {48'd0, p8}, e);
      check("bp_ov", {63'd0, ov8}, 64'd1);
      check("bp_rdy", {63'd0, ir8}, 64'd0);
      iv8 = (k == 2);
      a8  = 8'd3;
      b8  = 8'd3;
      @(negedge clk);
    end
    iv8 = 1'b0;
    check("bp_const", {48'd0, p8}, 64'h0078);
    or8 = 1'b1;
    @(negedge clk);
    check("bp_rel_ov", {63'd0, ov8}, 64'd0);
    check("bp_rel_rdy", {63'd0, ir8}, 64'd1);
    check("bp_rel_busy", {63'd0, bz8}, 64'd0);
    check("bp_hold_p", {48'd0, p8}, 64'h0078);
    @(negedge clk);
    check("bp_no_accept", {63'd0, bz8}, 64'd0);

    // Reset during CALC iteration 3
    send8(8'd200, 8'd200, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q8.delete();
    check("rstmid_p", {48'd0, p8}, 64'd0);
    check("rstmid_ov", {63'd0, ov8}, 64'd0);
    check("rstmid_rdy", {63'd0, ir8}, 64'd1);
    check("rstmid_busy", {63'd0, bz8}, 64'd0);
    send8(8'd7, 8'd6, 1'b0);
    recv8("after_rst_7x6");
    check("after_rst_const", {48'd0, p8}, 64'h002A);

    // Reset together with in_valid: not accepted
    rst = 1'b1;
    iv8 = 1'b1;
    a8  = 8'd5;
    b8  = 8'd5;
    @(negedge clk);
    rst = 1'b0;
    iv8 = 1'b0;
    check("rst_iv_rdy", {63'd0, ir8}, 64'd1);
    @(negedge clk);
    check("rst_iv_busy", {63'd0, bz8}, 64'd0);

    // WIDTH=16 random traffic with random stalls
    sent = 0;
    cyc  = 0;
    while ((sent < 1500 || q16.size() > 0) && cyc < 60000) begin
      or16 = 1'($urandom);
      if (ov16 && or16) begin
        e = (q16.size() > 0) ? q16.pop_front() : 64'hDEAD;
        check("rand16", {32'd0, p16}, e);
      end
      iv16 = (sent < 1500) ? 1'($urandom) : 1'b0;
      a16  = 16'($urandom);
      b16  = 16'($urandom);
      sg16 = 1'($urandom);
      if (iv16 && ir16) begin
        q16.push_back(ref_mul(16, {16'd0, a16}, {16'd0, b16}, sg16));
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    iv16 = 1'b0;
    check("rand16_sent", 64'(sent), 64'd1500);
    check("rand16_drain", 64'(q16.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
